// File: rtl/seq_div_unit.sv
// ---------------------------------------------------------------------------
// seq_div_unit
//   Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU. It produces
//   one quotient bit per clock. Every operand pair takes the same number of
//   cycles, including divide-by-zero and signed overflow.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   start        in   request, sampled only in IDLE or DONE
//   oprand_A     in   dividend, sampled with start
//   oprand_B     in   divisor, sampled with start
//   unsigned_sel in   1: unsigned operation, 0: two's complement
//   rem_sel      in   1: result is the remainder, 0: result is the quotient
//   busy         out  high while a division is in progress (CALC, FIX)
//   valid        out  one-cycle pulse in DONE; result is updated this cycle
//   result       out  quotient or remainder, held until the next valid
// ---------------------------------------------------------------------------
module seq_div_unit #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] oprand_A,
   input  logic [DATA_W-1:0] oprand_B,
   input  logic              unsigned_sel,
   input  logic              rem_sel,
   output logic              busy,
   output logic              valid,
   output logic [DATA_W-1:0] result
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state_q,     state_d;
   logic [DATA_W-1:0]   rem_q,       rem_d;
   logic [DATA_W-1:0]   quot_q,      quot_d;      // holds |A| initially, then the quotient
   logic [DATA_W-1:0]   a_mag_q,     a_mag_d;     // |A|, kept for the divide-by-zero remainder
   logic [DATA_W-1:0]   b_mag_q,     b_mag_d;
   logic [CNT_W-1:0]    cnt_q,       cnt_d;
   logic                a_neg_q,     a_neg_d;     // remainder takes this sign
   logic                q_neg_q,     q_neg_d;     // quotient must be negated
   logic                ovf_q,       ovf_d;       // signed MIN / -1
   logic                rem_sel_q,   rem_sel_d;
   logic [DATA_W-1:0]   result_q,    result_d;

   // Operand preprocessing for a newly accepted request
   logic                a_neg_in;
   logic                b_neg_in;
   logic [DATA_W-1:0]   a_mag_in;
   logic [DATA_W-1:0]   b_mag_in;
   logic                ovf_in;
   logic                accept;

   // One restoring step
   logic [DATA_W:0]     shifted;
   logic [DATA_W:0]     diff;
   logic                ge;

   // Sign fix-up and special cases
   logic [DATA_W-1:0]   q_fix;
   logic [DATA_W-1:0]   r_fix;
   logic [DATA_W-1:0]   dividend;
   logic [DATA_W-1:0]   q_final;
   logic [DATA_W-1:0]   r_final;

   always_comb begin
      a_neg_in = ~unsigned_sel & oprand_A[DATA_W-1];
      b_neg_in = ~unsigned_sel & oprand_B[DATA_W-1];
      a_mag_in = a_neg_in ? ({DATA_W{1'b0}} - oprand_A) : oprand_A;
      b_mag_in = b_neg_in ? ({DATA_W{1'b0}} - oprand_B) : oprand_B;
      ovf_in   = ~unsigned_sel
                 & (oprand_A == {1'b1, {(DATA_W-1){1'b0}}})
                 & (oprand_B == {DATA_W{1'b1}});
      accept   = start & ((state_q == S_IDLE) | (state_q == S_DONE));

      // The partial remainder is always below |B|, so the shifted value and
      // |B| both fit in DATA_W+1 bits. A non-negative difference also fits
      // back in DATA_W bits.
      shifted  = {rem_q, quot_q[DATA_W-1]};
      ge       = (shifted >= {1'b0, b_mag_q});
      diff     = shifted - {1'b0, b_mag_q};

      q_fix    = q_neg_q ? ({DATA_W{1'b0}} - quot_q) : quot_q;
      r_fix    = a_neg_q ? ({DATA_W{1'b0}} - rem_q)  : rem_q;
      dividend = a_neg_q ? ({DATA_W{1'b0}} - a_mag_q) : a_mag_q;

      if (b_mag_q == {DATA_W{1'b0}}) begin
         q_final = {DATA_W{1'b1}};
         r_final = dividend;
      end else if (ovf_q) begin
         q_final = {1'b1, {(DATA_W-1){1'b0}}};
         r_final = {DATA_W{1'b0}};
      end else begin
         q_final = q_fix;
         r_final = r_fix;
      end
   end

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      quot_d    = quot_q;
      a_mag_d   = a_mag_q;
      b_mag_d   = b_mag_q;
      cnt_d     = cnt_q;
      a_neg_d   = a_neg_q;
      q_neg_d   = q_neg_q;
      ovf_d     = ovf_q;
      rem_sel_d = rem_sel_q;
      result_d  = result_q;

      case (state_q)
         S_CALC: begin
            if (ge) begin
               rem_d  = diff[DATA_W-1:0];
               quot_d = {quot_q[DATA_W-2:0], 1'b1};
            end else begin
               rem_d  = shifted[DATA_W-1:0];
               quot_d = {quot_q[DATA_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            result_d = rem_sel_q ? r_final : q_final;
            state_d  = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // IDLE and DONE share the same acceptance path, so back-to-back
      // requests skip IDLE entirely.
      if (accept) begin
         rem_d     = {DATA_W{1'b0}};
         quot_d    = a_mag_in;
         a_mag_d   = a_mag_in;
         b_mag_d   = b_mag_in;
         cnt_d     = CNT_W'(DATA_W);
         a_neg_d   = a_neg_in;
         q_neg_d   = a_neg_in ^ b_neg_in;
         ovf_d     = ovf_in;
         rem_sel_d = rem_sel;
         state_d   = S_CALC;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         rem_q     <= '0;
         quot_q    <= '0;
         a_mag_q   <= '0;
         b_mag_q   <= '0;
         cnt_q     <= '0;
         a_neg_q   <= 1'b0;
         q_neg_q   <= 1'b0;
         ovf_q     <= 1'b0;
         rem_sel_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         quot_q    <= quot_d;
         a_mag_q   <= a_mag_d;
         b_mag_q   <= b_mag_d;
         cnt_q     <= cnt_d;
         a_neg_q   <= a_neg_d;
         q_neg_q   <= q_neg_d;
         ovf_q     <= ovf_d;
         rem_sel_q <= rem_sel_d;
         result_q  <= result_d;
      end
   end

   assign busy   = (state_q == S_CALC) | (state_q == S_FIX);
   assign valid  = (state_q == S_DONE);
   assign result = result_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_div_unit
//   Directed table of division vectors with hand-computed results. There are
//   also hand-written sequences for a start pulse ignored mid-CALC, a
//   back-to-back start in DONE, and a reset asserted mid-operation.
// ---------------------------------------------------------------------------
module tb_seq_div_unit;

   localparam int DATA_W  = 32;
   localparam int LATENCY = DATA_W + 1;

   logic              clk;
   logic              rst;
   logic              start;
   logic [DATA_W-1:0] oprand_A;
   logic [DATA_W-1:0] oprand_B;
   logic              unsigned_sel;
   logic              rem_sel;
   logic              busy;
   logic              valid;
   logic [DATA_W-1:0] result;

   seq_div_unit #(.DATA_W(DATA_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .oprand_A     (oprand_A),
      .oprand_B     (oprand_B),
      .unsigned_sel (unsigned_sel),
      .rem_sel      (rem_sel),
      .busy         (busy),
      .valid        (valid),
      .result       (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        u;
      logic        r;
      logic [31:0] exp;
      string       name;
   } vec_t;

   int          pass_cnt = 0;
   int          tot_cnt  = 0;
   logic [31:0] prev_result = '0;
   vec_t        vecs[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Issue one op and wait for valid. from_done: the caller is already at #1
   // after an edge in DONE, so start is driven immediately (back-to-back).
   // glitch > 0: pulse start with other operands at that cycle count.
   task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic u, input logic r, input logic [31:0] exp,
                         input bit from_done, input int glitch);
      int  n;
      bit  hold_ok;
      if (!from_done) @(negedge clk);
      oprand_A     = a;
      oprand_B     = b;
      unsigned_sel = u;
      rem_sel      = r;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start        = 1'b0;
      oprand_A     = ~a;          // inputs may change freely after the start edge
      oprand_B     = 32'h5;
      unsigned_sel = ~u;
      rem_sel      = ~r;
      n       = 0;
      hold_ok = 1'b1;
      while (1) begin
         @(posedge clk);
         #1;
         n++;
         if (glitch > 0 && n == glitch) begin
            start    = 1'b1;
            oprand_A = 32'd5;
            oprand_B = 32'd1;
         end
         if (glitch > 0 && n == glitch + 1) start = 1'b0;
         if (valid) break;
         if (result !== prev_result) hold_ok = 1'b0;
         if (n > 60) break;
      end
      chk({nm, " latency"}, n, LATENCY);
      chk({nm, " result"}, result, exp);
      chk({nm, " held"}, {31'd0, hold_ok}, 32'd1);
      $display("op %s: A=0x%08h B=0x%08h u=%0d r=%0d -> result=0x%08h after %0d cycles",
               nm, a, b, u, r, result, n);
      prev_result = result;
   endtask

   initial begin
      int nvalid;

      vecs[0]  = '{32'd100,       32'd7,         1'b0, 1'b0, 32'd14,        "s 100/7 q"};
      vecs[1]  = '{32'd100,       32'd7,         1'b0, 1'b1, 32'd2,         "s 100/7 r"};
      vecs[2]  = '{32'hFFFFFF9C,  32'd7,         1'b0, 1'b0, 32'hFFFFFFF2,  "s -100/7 q"};
      vecs[3]  = '{32'hFFFFFF9C,  32'd7,         1'b0, 1'b1, 32'hFFFFFFFE,  "s -100/7 r"};
      vecs[4]  = '{32'd100,       32'hFFFFFFF9,  1'b0, 1'b0, 32'hFFFFFFF2,  "s 100/-7 q"};
      vecs[5]  = '{32'd100,       32'hFFFFFFF9,  1'b0, 1'b1, 32'd2,         "s 100/-7 r"};
      vecs[6]  = '{32'h1234,      32'd0,         1'b0, 1'b0, 32'hFFFFFFFF,  "s div0 q"};
      vecs[7]  = '{32'h1234,      32'd0,         1'b1, 1'b1, 32'h1234,      "u div0 r"};
      vecs[8]  = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 1'b0, 32'h80000000,  "s ovf q"};
      vecs[9]  = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 1'b1, 32'd0,         "s ovf r"};
      vecs[10] = '{32'hFFFFFFFF,  32'd2,         1'b1, 1'b0, 32'h7FFFFFFF,  "u max/2 q"};
      vecs[11] = '{32'hFFFFFFFF,  32'd2,         1'b1, 1'b1, 32'd1,         "u max/2 r"};
      vecs[12] = '{32'hFFFFFFFF,  32'd2,         1'b0, 1'b0, 32'd0,         "s -1/2 q"};
      vecs[13] = '{32'hFFFFFFFF,  32'd2,         1'b0, 1'b1, 32'hFFFFFFFF,  "s -1/2 r"};
      vecs[14] = '{32'hFFFFFFF9,  32'd0,         1'b0, 1'b1, 32'hFFFFFFF9,  "s -7/0 r"};
      vecs[15] = '{32'hDEADBEEF,  32'h10,        1'b1, 1'b0, 32'h0DEADBEE,  "u dead/16 q"};

      rst          = 1'b1;
      start        = 1'b0;
      oprand_A     = '0;
      oprand_B     = '0;
      unsigned_sel = 1'b0;
      rem_sel      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy",   {31'd0, busy},  32'd0);
      chk("reset valid",  {31'd0, valid}, 32'd0);
      chk("reset result", result,         32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].u, vecs[i].r,
                vecs[i].exp, 1'b0, 0);
         chk({vecs[i].name, " busy at valid"}, {31'd0, busy}, 32'd0);
         if (i % 2 == 1) @(posedge clk);   // some ops start from IDLE, others from DONE
      end

      // A start pulse during CALC is ignored.
      run_op("glitch 1000/3", 32'd1000, 32'd3, 1'b1, 1'b0, 32'd333, 1'b0, 5);

      // A start held in DONE is accepted back-to-back.
      run_op("chain a 77/5", 32'd77, 32'd5, 1'b1, 1'b1, 32'd2, 1'b0, 0);
      run_op("chain b 77/5", 32'd77, 32'd5, 1'b1, 1'b0, 32'd15, 1'b1, 0);
      @(posedge clk);

      // Reset mid-CALC aborts the op.
      @(negedge clk);
      oprand_A     = 32'hFFFFFFFF;
      oprand_B     = 32'd2;
      unsigned_sel = 1'b1;
      rem_sel      = 1'b0;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("mid busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("abort busy",   {31'd0, busy},  32'd0);
      chk("abort valid",  {31'd0, valid}, 32'd0);
      chk("abort result", result,         32'd0);
      @(negedge clk);
      rst = 1'b0;
      prev_result = '0;
      nvalid = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (valid) nvalid++;
      end
      chk("no valid after abort", nvalid, 0);
      run_op("post-reset max/2", 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b0, 0);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
